// File: rtl/conv_sched_if.sv
// Host/scheduler signal bundle for conv_sched: burst control and configuration in,
// launch pulse, capture enable and progress counters out.
interface conv_sched_if #(
    parameter int CNT_WIDTH  = 16,
    parameter int TIME_WIDTH = 16
);
    logic                  START;
    logic                  ABORT;
    logic [CNT_WIDTH-1:0]  NUM_CONV;
    logic [TIME_WIDTH-1:0] PERIOD;
    logic [TIME_WIDTH-1:0] CAPT_DELAY;
    logic [7:0]            CAPT_LEN;
    logic                  FIFO_ALMOST_FULL;
    logic                  SEQ_START;
    logic                  CAPT_EN;
    logic                  BUSY;
    logic                  DONE;
    logic [CNT_WIDTH-1:0]  CONV_CNT;
    logic [CNT_WIDTH-1:0]  STALL_CNT;

    modport master (
        output START, ABORT, NUM_CONV, PERIOD, CAPT_DELAY, CAPT_LEN, FIFO_ALMOST_FULL,
        input  SEQ_START, CAPT_EN, BUSY, DONE, CONV_CNT, STALL_CNT
    );

    modport slave (
        input  START, ABORT, NUM_CONV, PERIOD, CAPT_DELAY, CAPT_LEN, FIFO_ALMOST_FULL,
        output SEQ_START, CAPT_EN, BUSY, DONE, CONV_CNT, STALL_CNT
    );
endinterface

// File: rtl/conv_sched.sv
// Conversion scheduler: launches a burst of ADC conversions at a fixed period,
// opens a capture window per conversion and throttles on FIFO almost-full.
module conv_sched #(
    parameter int CNT_WIDTH  = 16,
    parameter int TIME_WIDTH = 16
) (
    input  logic         SEQ_CLK,
    input  logic         RESET,
    conv_sched_if.slave  bus
);
    localparam int TW1 = TIME_WIDTH + 1;
    localparam logic [TW1-1:0]       T_ONE   = TW1'(1);
    localparam logic [TW1-1:0]       T_TWO   = TW1'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_t;

    state_t                state_q, state_d;
    logic [TW1-1:0]        t_q, t_d;
    logic [TW1-1:0]        peff_q, peff_d;
    logic [TW1-1:0]        delay_q, delay_d;
    logic [TW1-1:0]        capt_end_q, capt_end_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  conv_cnt_q, conv_cnt_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic                  done_q, done_d;
    logic                  seq_start_q, seq_start_d;
    logic                  capt_en_q, capt_en_d;
    logic                  busy_q, busy_d;

    // Effective period: long enough to hold the capture window, never below 2.
    logic [TW1-1:0] delay_in, win_end_in, period_in, peff_in;

    always_comb begin
        delay_in   = {1'b0, bus.CAPT_DELAY};
        win_end_in = delay_in + {{(TW1-8){1'b0}}, bus.CAPT_LEN};
        period_in  = {1'b0, bus.PERIOD};
        peff_in    = (period_in > win_end_in) ? period_in : win_end_in;
        if (peff_in < T_TWO) begin
            peff_in = T_TWO;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge SEQ_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            peff_q      <= '0;
            delay_q     <= '0;
            capt_end_q  <= '0;
            num_q       <= '0;
            conv_cnt_q  <= '0;
            stall_cnt_q <= '0;
            done_q      <= 1'b0;
            seq_start_q <= 1'b0;
            capt_en_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            peff_q      <= peff_d;
            delay_q     <= delay_d;
            capt_end_q  <= capt_end_d;
            num_q       <= num_d;
            conv_cnt_q  <= conv_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            done_q      <= done_d;
            seq_start_q <= seq_start_d;
            capt_en_q   <= capt_en_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every comb output gets a default first, otherwise unassigned paths infer latches.
        state_d     = state_q;
        t_d         = t_q;
        peff_d      = peff_q;
        delay_d     = delay_q;
        capt_end_d  = capt_end_q;
        num_d       = num_q;
        conv_cnt_d  = conv_cnt_q;
        stall_cnt_d = stall_cnt_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START && !bus.ABORT) begin
                    num_d       = bus.NUM_CONV;
                    delay_d     = delay_in;
                    capt_end_d  = win_end_in;
                    peff_d      = peff_in;
                    conv_cnt_d  = '0;
                    stall_cnt_d = '0;
                    t_d         = '0;
                    state_d     = bus.FIFO_ALMOST_FULL ? S_STALL : S_RUN;
                end
            end

            S_RUN: begin
                if (t_q == '0) begin
                    conv_cnt_d = conv_cnt_q + CNT_ONE;
                end
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                end else if (t_q == peff_q - T_ONE) begin
                    // Period >= 2, so the count already includes this conversion.
                    if (num_q != '0 && conv_cnt_q == num_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (bus.FIFO_ALMOST_FULL) begin
                        state_d = S_STALL;
                    end else begin
                        t_d = '0;
                    end
                end else begin
                    t_d = t_q + T_ONE;
                end
            end

            S_STALL: begin
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_ONE;
                end
                if (bus.ABORT) begin
                    state_d = S_IDLE;
                end else if (!bus.FIFO_ALMOST_FULL) begin
                    state_d = S_RUN;
                    t_d     = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Output logic, decoded from the next state so the outputs come straight from flops.
    always_comb begin
        seq_start_d = (state_d == S_RUN) && (t_d == '0);
        capt_en_d   = (state_d == S_RUN) && (t_d >= delay_d) && (t_d < capt_end_d);
        busy_d      = (state_d != S_IDLE);
    end

    assign bus.SEQ_START = seq_start_q;
    assign bus.CAPT_EN   = capt_en_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.CONV_CNT  = conv_cnt_q;
    assign bus.STALL_CNT = stall_cnt_q;
endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: directed scenarios plus randomized bursts
// compared cycle by cycle against an event-level reference model.
module tb_conv_sched;
    localparam int CW   = 16;
    localparam int TW   = 16;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_sched_if #(.CNT_WIDTH(CW), .TIME_WIDTH(TW)) bus ();

    conv_sched #(.CNT_WIDTH(CW), .TIME_WIDTH(TW)) dut (
        .SEQ_CLK (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    bit af     [MAXC];
    bit e_seq  [MAXC];
    bit e_capt [MAXC];
    bit e_busy [MAXC];
    bit e_done [MAXC];
    bit e_stall[MAXC];
    int m_conv  = 0;
    int m_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_af();
        for (int i = 0; i < MAXC; i++) af[i] = 1'b0;
    endtask

    // Reference: walk the burst conversion by conversion, marking launch, window,
    // stall and done cycles; anything after an abort/reset cycle is dropped.
    task automatic build_model(input int n, input int period, input int delay, input int len,
                               input int abort_at, input int rst_at, input bit start_abort,
                               output int fin);
        int cut, pe, launch, cnt, e, s, done;
        for (int i = 0; i < MAXC; i++) begin
            e_seq[i] = 0; e_capt[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_stall[i] = 0;
        end
        cut = MAXC - 64;
        if (abort_at >= 0 && abort_at < cut) cut = abort_at;
        if (rst_at >= 0 && rst_at < cut) cut = rst_at;
        if (start_abort) begin
            fin = 2;
            return;
        end
        pe = period;
        if (delay + len > pe) pe = delay + len;
        if (pe < 2) pe = 2;
        launch = 1;
        if (af[0]) begin
            s = 1;
            while (s < MAXC - 1 && af[s]) s++;
            for (int x = 1; x <= s; x++) if (x <= cut) begin e_stall[x] = 1; e_busy[x] = 1; end
            launch = s + 1;
        end
        cnt = 0;
        done = -1;
        while (launch <= cut) begin
            e_seq[launch] = 1;
            for (int x = launch; x < launch + pe; x++) if (x <= cut) e_busy[x] = 1;
            for (int x = launch + delay; x < launch + delay + len; x++) if (x <= cut) e_capt[x] = 1;
            cnt++;
            e = launch + pe - 1;
            if (n != 0 && cnt == n) begin
                if (e + 1 <= cut) done = e + 1;
                break;
            end
            if (e < MAXC - 1 && af[e]) begin
                s = e + 1;
                while (s < MAXC - 1 && af[s]) s++;
                for (int x = e + 1; x <= s; x++) if (x <= cut) begin e_stall[x] = 1; e_busy[x] = 1; end
                launch = s + 1;
            end else begin
                launch = e + 1;
            end
        end
        if (done >= 0) begin
            e_done[done] = 1;
            fin = done;
        end else begin
            fin = cut + 1;
        end
    endtask

    task automatic run_case(input string name, input int n, input int period, input int delay,
                            input int len, input int abort_at, input int rst_at,
                            input bit start_abort);
        int fin, len_c, rc, rs, ec, es;
        logic [3:0] got_v, exp_v;
        build_model(n, period, delay, len, abort_at, rst_at, start_abort, fin);
        len_c = fin + 4;
        rc = 0;
        rs = 0;
        for (int c = 0; c < len_c; c++) begin
            @(posedge clk);
            #1;
            if (c == 0 || start_abort) begin
                ec = m_conv;
                es = m_stall;
            end else if (rst_at >= 0 && c > rst_at) begin
                ec = 0;
                es = 0;
            end else begin
                ec = rc % 65536;
                es = (rs > 65535) ? 65535 : rs;
            end
            got_v = {bus.SEQ_START, bus.CAPT_EN, bus.BUSY, bus.DONE};
            exp_v = {e_seq[c], e_capt[c], e_busy[c], e_done[c]};
            check($sformatf("%s seq/capt/busy/done c%0d", name, c), 32'(got_v), 32'(exp_v));
            check($sformatf("%s conv_cnt c%0d", name, c), 32'(bus.CONV_CNT), 32'(ec));
            check($sformatf("%s stall_cnt c%0d", name, c), 32'(bus.STALL_CNT), 32'(es));
            if (!start_abort) begin
                if (e_seq[c]) rc++;
                if (e_stall[c]) rs++;
            end
            // Inputs for cycle c
            if (c == 0) begin
                bus.START      = 1'b1;
                bus.ABORT      = start_abort;
                bus.NUM_CONV   = CW'(n);
                bus.PERIOD     = TW'(period);
                bus.CAPT_DELAY = TW'(delay);
                bus.CAPT_LEN   = 8'(len);
            end else begin
                // Config churn and stray STARTs while busy must have no effect.
                bus.START      = e_busy[c] && ($urandom_range(0, 5) == 0);
                bus.ABORT      = (c == abort_at);
                bus.NUM_CONV   = CW'($urandom);
                bus.PERIOD     = TW'($urandom);
                bus.CAPT_DELAY = TW'($urandom);
                bus.CAPT_LEN   = 8'($urandom);
            end
            rst = (c == rst_at);
            bus.FIFO_ALMOST_FULL = af[c];
        end
        if (rst_at >= 0) begin
            m_conv  = 0;
            m_stall = 0;
        end else if (!start_abort) begin
            m_conv  = rc % 65536;
            m_stall = (rs > 65535) ? 65535 : rs;
        end
    endtask

    initial begin
        int n, p, d, l, ab;
        rst = 1'b1;
        bus.START = 0; bus.ABORT = 0; bus.NUM_CONV = '0; bus.PERIOD = '0;
        bus.CAPT_DELAY = '0; bus.CAPT_LEN = '0; bus.FIFO_ALMOST_FULL = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {26'd0, bus.SEQ_START, bus.CAPT_EN, bus.BUSY, bus.DONE}, 32'd0);
        check("reset conv_cnt", 32'(bus.CONV_CNT), 32'd0);
        check("reset stall_cnt", 32'(bus.STALL_CNT), 32'd0);
        rst = 1'b0;

        clear_af();
        run_case("basic", 3, 10, 2, 4, -1, -1, 1'b0);
        run_case("clamp", 2, 3, 2, 4, -1, -1, 1'b0);
        run_case("clamp0", 2, 0, 0, 0, -1, -1, 1'b0);
        for (int i = 5; i <= 14; i++) af[i] = 1'b1;
        run_case("backpressure", 3, 10, 2, 4, -1, -1, 1'b0);
        clear_af();
        run_case("continuous", 0, 8, 2, 4, 50, -1, 1'b0);
        run_case("start_abort", 3, 10, 2, 4, -1, -1, 1'b1);
        run_case("relaunch", 1, 10, 2, 4, -1, -1, 1'b0);
        run_case("reset_mid", 3, 10, 2, 4, -1, 4, 1'b0);
        run_case("after_reset", 3, 10, 2, 4, -1, -1, 1'b0);
        af[0] = 1'b1; af[1] = 1'b1;
        run_case("start_stalled", 2, 5, 1, 2, -1, -1, 1'b0);

        for (int k = 0; k < 25; k++) begin
            clear_af();
            for (int i = 0; i < 400; i++) af[i] = ($urandom_range(0, 5) == 0);
            n = $urandom_range(0, 4);
            p = $urandom_range(0, 20);
            d = $urandom_range(0, 10);
            l = $urandom_range(0, 8);
            if (n == 0) ab = $urandom_range(3, 120);
            else if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, 60);
            else ab = -1;
            run_case($sformatf("rand%0d", k), n, p, d, l, ab, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
